// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter
//   Registered N-way arbiter with a software-selectable policy: fixed priority
//   (lowest index wins) or round-robin (scan starts one past the last owner).
//   A grant is held until the owner signals done, drops its request, or hits
//   HOLD_MAX consecutive cycles. There is always one idle cycle between grants.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mode         0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   req[N]       level-sensitive request vector
//   done[N]      release strobe; only the current owner's bit is honoured
//   grant[N]     registered one-hot grant
//   grant_valid  registered OR of grant
//   grant_id     binary index of owner; keeps the last owner while idle
//   timeout      one-cycle pulse after a grant is revoked at HOLD_MAX
//   onehot_err   sticky flag, set if grant ever has more than one bit high
module prio_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8,
    localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           timeout,
    output logic           onehot_err
);

    localparam int unsigned CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;
    logic           onehot_err_q, onehot_err_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] scan_id;
    logic           owner_done, owner_req, at_max, multi_hot;

    // Winner selection. Loops run from the far end downwards so the last hit
    // assigned is the one closest to the scan start.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_id   = '0;
        if (!mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[IDW'(i)]) begin
                    win_found = 1'b1;
                    win_id    = IDW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                scan_id = IDW'((int'(rr_ptr_q) + k) % int'(N));
                if (req[scan_id]) begin
                    win_found = 1'b1;
                    win_id    = scan_id;
                end
            end
        end
    end

    assign owner_done = done[grant_id_q];
    assign owner_req  = req[grant_id_q];
    assign at_max     = (hold_cnt_q == CW'(HOLD_MAX));
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_hot  = ((grant_q & (grant_q - 1'b1)) != '0);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = 1'b0;
        onehot_err_d = onehot_err_q | multi_hot;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d    = N'(1) << win_id;
                    grant_id_d = win_id;
                    hold_cnt_d = CW'(1);
                    state_d    = StOwn;
                end
            end
            StOwn: begin
                if (owner_done || !owner_req || at_max) begin
                    grant_d  = '0;
                    state_d  = StIdle;
                    rr_ptr_d = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;
                    // Only a forced revocation counts; a voluntary release wins.
                    timeout_d = at_max && !owner_done && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            onehot_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
            onehot_err_q  <= onehot_err_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;
    assign onehot_err  = onehot_err_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed table-driven bench for prio_rr_arbiter (N=4, HOLD_MAX=8).
// Each vector: inputs applied just after an edge, outputs checked 1 time unit
// after the following edge.
module tb_prio_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;
    logic       onehot_err;

    prio_rr_arbiter #(
        .N        (4),
        .HOLD_MAX (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout),
        .onehot_err  (onehot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [3:0] r;
        logic [3:0] d;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic check_outs(input string tname, input int idx, input logic [3:0] g,
                              input logic v, input logic [1:0] id, input logic to);
        check({tname, ".grant"}, idx, 32'(grant), 32'(g));
        check({tname, ".grant_valid"}, idx, 32'(grant_valid), 32'(v));
        check({tname, ".grant_id"}, idx, 32'(grant_id), 32'(id));
        check({tname, ".timeout"}, idx, 32'(timeout), 32'(to));
        check({tname, ".onehot_err"}, idx, 32'(onehot_err), 32'(0));
    endtask

    task automatic add(input logic m, input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] g, input logic v, input logic [1:0] id,
                       input logic to);
        vec_t x;
        x.m = m; x.r = r; x.d = d; x.g = g; x.v = v; x.id = id; x.to = to;
        vecs.push_back(x);
    endtask

    task automatic run_table(input string tname);
        foreach (vecs[i]) begin
            mode = vecs[i].m;
            req  = vecs[i].r;
            done = vecs[i].d;
            @(posedge clk);
            #1;
            check_outs(tname, i, vecs[i].g, vecs[i].v, vecs[i].id, vecs[i].to);
        end
        vecs.delete();
        done = 4'b0000;
    endtask

    task automatic do_reset(input string tname);
        mode  = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outs({tname, ".reset"}, 0, 4'b0000, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        mode  = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;

        // Idle with no requests.
        do_reset("idle");
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        run_table("idle");

        // Fixed priority: requester 1 always beats 3; done after 2 grant cycles.
        do_reset("fixed");
        for (int i = 0; i < 2; i++) begin
            add(0, 4'b1010, 4'b0000, 4'b0010, 1, 1, 0);
            add(0, 4'b1010, 4'b0000, 4'b0010, 1, 1, 0);
            add(0, 4'b1010, 4'b0010, 4'b0000, 0, 1, 0);
        end
        run_table("fixed");

        // Round-robin rotation 0,1,3,0 with an idle cycle between grants.
        do_reset("rr");
        add(1, 4'b1011, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b1011, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b1011, 4'b0001, 4'b0000, 0, 0, 0);
        add(1, 4'b1011, 4'b0000, 4'b0010, 1, 1, 0);
        add(1, 4'b1011, 4'b0000, 4'b0010, 1, 1, 0);
        add(1, 4'b1011, 4'b0010, 4'b0000, 0, 1, 0);
        add(1, 4'b1011, 4'b0000, 4'b1000, 1, 3, 0);
        add(1, 4'b1011, 4'b0000, 4'b1000, 1, 3, 0);
        add(1, 4'b1011, 4'b1000, 4'b0000, 0, 3, 0);
        add(1, 4'b1011, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b1011, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b1011, 4'b0001, 4'b0000, 0, 0, 0);
        run_table("rr");

        // Hold limit: 8 grant cycles, timeout pulse, gap, re-grant. The later
        // req=1111 grant to 3 shows rr_ptr advanced to 3 after owner 2.
        for (int i = 0; i < 8; i++) add(1, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0);
        add(1, 4'b0100, 4'b0000, 4'b0000, 0, 2, 1);
        add(1, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0);
        add(1, 4'b0100, 4'b0100, 4'b0000, 0, 2, 0);
        add(1, 4'b1111, 4'b0000, 4'b1000, 1, 3, 0);
        add(1, 4'b1111, 4'b1000, 4'b0000, 0, 3, 0);
        add(1, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        run_table("hold");

        // done on the HOLD_MAX cycle wins (no timeout); non-owner done ignored.
        do_reset("donemax");
        add(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 4'b0100, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 4'b1101, 4'b0010, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 4'b0010, 4'b0000, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0);
        run_table("donemax");

        // Asynchronous reset mid-grant, then arbitration restarts at rr_ptr=0.
        do_reset("async");
        add(1, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0);
        run_table("async.pre");
        req = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async.drop", 0, 4'b0000, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(1, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 4'b1001, 4'b0001, 4'b0000, 0, 0, 0);
        add(1, 4'b1001, 4'b0000, 4'b1000, 1, 3, 0);
        run_table("async.post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prio_rr_arbiter.md
Name: prio_rr_arbiter

Overview:
- Registered arbiter that shares one resource among N requesters.
- Two software-selectable policies:
  - fixed priority: ordered "priority" evaluation, lowest index wins.
  - round-robin: rotating "priority" starting after the last owner.
- Grant is always one-hot or zero, so downstream mux/decode logic can use "unique" selection safely.
- A hold-time limit stops any single owner from monopolising the resource.

Parameters:
- N, 4, number of requesters (2..16).
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held (>=2).
- IDW, $clog2(N), width of grant_id (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only when arbitrating.
- req  in  N  request vector, level-sensitive.
- done  in  N  per-requester release strobe; only the owner's bit is honoured.
- grant  out  N  one-hot grant, registered.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  IDW  binary index of owner; holds last owner when grant_valid=0.
- timeout  out  1  one-cycle pulse when a grant is revoked at HOLD_MAX.
- onehot_err  out  1  sticky flag, set if grant ever has more than one bit set; must never assert.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - grant=0, grant_valid=0, grant_id=0, timeout=0, onehot_err=0.
  - Internal: rr_ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, OWN.
- IDLE, req==0: stay IDLE, outputs stay 0.
- IDLE, req!=0: pick winner combinationally; on the next edge:
  - grant=1<<w, grant_id=w, grant_valid=1, hold_cnt=1, state=OWN.
  - Latency from req to grant is 1 cycle.
- Winner selection:
  - mode=0: smallest index i with req[i]=1.
  - mode=1: first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
- OWN, owner o: release at the next edge when any of these holds:
  - (a) done[o]=1;
  - (b) req[o]=0;
  - (c) hold_cnt==HOLD_MAX. In this case timeout=1 during the cycle after the edge only.
- OWN, no release condition: hold grant, hold_cnt increments by 1.
- On release:
  - grant=0, grant_valid=0, state=IDLE, rr_ptr=(o+1) mod N.
  - There is always one idle cycle between grants. Back-to-back grants without a gap are not allowed.
- Simultaneous events:
  - If done[o] and hold_cnt==HOLD_MAX occur together, done wins and timeout stays 0.
  - done bits of non-owners are ignored in all states.
  - Changes to req of non-owners during OWN have no effect until the next IDLE.
- mode changes during OWN take effect at the next arbitration. rr_ptr is maintained in both modes.
- Wrap-around: rr_ptr wraps from N-1 to 0. A non-power-of-2 N must wrap correctly, e.g. N=3 gives 2 -> 0.
- onehot_err: set on any edge where more than one bit of grant is high. Cleared only by reset.
- Reset asserted mid-grant: all outputs drop immediately (asynchronously). After reset, arbitration restarts from rr_ptr=0.

Test Plan (N=4, HOLD_MAX=8):
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- mode=0, req=4'b1010 held, each owner pulses done after 2 cycles:
  - Grant sequence is 0010, idle, 0010, idle, ...
  - Requester 3 is never granted.
- mode=1, req=4'b1011 held, done pulsed on the 2nd cycle of each grant:
  - Grants rotate 0001, 0010, 1000, 0001.
  - grant_id rotates 0, 1, 3, 0.
  - One idle cycle between each grant.
- mode=1, req=4'b0100 held, done never asserted:
  - Grant 0100 lasts exactly 8 cycles.
  - timeout pulses once, then a 1-cycle gap.
  - Requester 2 is re-granted and rr_ptr=3.
- Owner 1 asserts done on the same cycle hold_cnt==8 -> released, timeout=0. Separately, done[2] pulsed while owner is 1 -> no effect.
- rst_n driven low for 1 cycle while grant=4'b1000 -> grant=0 immediately, no clock needed. Next req=4'b1001 in mode=1 grants 0001 (rr_ptr reset to 0). onehot_err=0 at the end of every test.
